ad9958_spi_slave: RTL

AD9958_SPI_SLAVE -- requirements
Module: ad9958_spi_slave

---
 rtl/ad9958_pkg.sv | 44 ++++
 rtl/ad9958_input_sync.sv | 37 +++
 rtl/ad9958_spi_slave.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ad9958_pkg.sv
// Shared definitions for the AD9958 serial-port slave: register map,
// register length table, CSR reset value and the FSM state type.
package ad9958_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INSTR  = 2'd1,
    ST_DATA   = 2'd2,
    ST_IGNORE = 2'd3
  } state_e;

  localparam logic [2:0] ADDR_CSR   = 3'd0;
  localparam logic [2:0] ADDR_FR1   = 3'd1;
  localparam logic [2:0] ADDR_FR2   = 3'd2;
  localparam logic [2:0] ADDR_CFR   = 3'd3;
  localparam logic [2:0] ADDR_CFTW0 = 3'd4;
  localparam logic [2:0] ADDR_CPOW0 = 3'd5;
  localparam logic [2:0] ADDR_ACR   = 3'd6;

  // Highest address that is accepted; anything above is rejected.
  localparam logic [6:0] ADDR_MAX   = 7'd6;

  localparam logic [7:0] CSR_DEFAULT = 8'hF0;

  // Register length in bytes, indexed by register address.
  function automatic logic [2:0] reg_len_bytes(input logic [2:0] addr);
    case (addr)
      ADDR_CSR:   reg_len_bytes = 3'd1;
      ADDR_FR1:   reg_len_bytes = 3'd3;
      ADDR_FR2:   reg_len_bytes = 3'd2;
      ADDR_CFR:   reg_len_bytes = 3'd3;
      ADDR_CFTW0: reg_len_bytes = 3'd4;
      ADDR_CPOW0: reg_len_bytes = 3'd2;
      ADDR_ACR:   reg_len_bytes = 3'd3;
      default:    reg_len_bytes = 3'd1;
    endcase
  endfunction

  // Register length in bits (bytes * 8).
  function automatic logic [5:0] reg_len_bits(input logic [2:0] addr);
    reg_len_bits = {reg_len_bytes(addr), 3'b000};
  endfunction

endpackage

// File: rtl/ad9958_input_sync.sv
// Two-flop synchronizer for a bundle of asynchronous pins, with rising and
// falling edge strobes derived from the synchronized value.
module ad9958_input_sync #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  // Two synchronizing stages plus one history stage for edge detection;
  // reset to the idle pin levels so no false edge appears after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ad9958_spi_slave.sv
// AD9958-style serial write port: decodes instruction/data frames into
// per-channel buffer registers and transfers them to the active outputs on
// io_update. Handshake: there is no valid/ready pair; a frame is bounded by
// cs low, each synchronized sclk rising edge carries one bit (or one nibble
// in 4-bit mode), and io_update is a fire-and-forget transfer strobe.
module ad9958_spi_slave
  import ad9958_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        sclk,
  input  logic [3:0]  sdio,
  input  logic        master_reset,
  input  logic        io_update,
  output logic [31:0] ftw_ch0,
  output logic [31:0] ftw_ch1,
  output logic [23:0] acr_ch0,
  output logic [23:0] acr_ch1,
  output logic        update_pulse,
  output logic        frame_error,
  output logic [1:0]  dbg_state
);

  // Synchronized pin bundle: {io_update, master_reset, sclk, cs, sdio[3:0]}.
  logic [7:0] sync_q, sync_rise, sync_fall;

  ad9958_input_sync #(
    .WIDTH     (8),
    .RESET_VAL (8'h10)
  ) u_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    ({io_update, master_reset, sclk, cs, sdio}),
    .q_o    (sync_q),
    .rise_o (sync_rise),
    .fall_o (sync_fall)
  );

  logic [3:0] sdio_s;
  logic       cs_s, cs_rise, cs_fall, sclk_rise, mr_s, io_rise;
  assign sdio_s    = sync_q[3:0];
  assign cs_s      = sync_q[4];
  assign cs_rise   = sync_rise[4];
  assign cs_fall   = sync_fall[4];
  assign sclk_rise = sync_rise[5];
  assign mr_s      = sync_q[6];
  assign io_rise   = sync_rise[7];

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [2:0]  addr_q, addr_d;
  logic [7:0]  csr_q;
  logic [31:0] ftw_buf0_q, ftw_buf1_q, ftw0_q, ftw1_q;
  logic [23:0] acr_buf0_q, acr_buf1_q, acr0_q, acr1_q;
  logic        update_pulse_q, frame_error_q;

  // Bits consumed per sclk edge follow the CSR as it stands; a CSR write
  // only lands at a word boundary, so a mode change starts with the next
  // instruction byte.
  logic        nibble_mode, sample;
  logic [31:0] shift_nxt;
  logic [5:0]  cnt_nxt;
  logic        instr_done, instr_ok, word_done;

  assign nibble_mode = (csr_q[2:1] == 2'b11);
  assign sample      = sclk_rise && !cs_s &&
                       ((state_q == ST_INSTR) || (state_q == ST_DATA));
  assign shift_nxt   = nibble_mode ? {shift_q[27:0], sdio_s}
                                   : {shift_q[30:0], sdio_s[0]};
  assign cnt_nxt     = cnt_q + (nibble_mode ? 6'd4 : 6'd1);
  assign instr_done  = sample && (state_q == ST_INSTR) && (cnt_nxt == 6'd8);
  assign instr_ok    = !shift_nxt[7] && (shift_nxt[6:0] <= ADDR_MAX);
  assign word_done   = sample && (state_q == ST_DATA) &&
                       (cnt_nxt == reg_len_bits(addr_q));

  // FSM state register together with the bit counter and shifter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
    end else if (mr_s) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic: cs rising always wins and returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d = ST_INSTR;
            cnt_d   = '0;
          end
        end
        ST_INSTR: begin
          if (sample) begin
            shift_d = shift_nxt;
            cnt_d   = cnt_nxt;
            if (instr_done) begin
              cnt_d   = '0;
              addr_d  = shift_nxt[2:0];
              state_d = instr_ok ? ST_DATA : ST_IGNORE;
            end
          end
        end
        ST_DATA: begin
          if (sample) begin
            shift_d = shift_nxt;
            cnt_d   = cnt_nxt;
            if (word_done) begin
              cnt_d   = '0;
              state_d = ST_INSTR;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: commit strobes and frame error condition.
  logic commit_csr, commit_ftw, commit_acr, frame_err_d;
  always_comb begin
    commit_csr  = word_done && (addr_q == ADDR_CSR);
    commit_ftw  = word_done && (addr_q == ADDR_CFTW0);
    commit_acr  = word_done && (addr_q == ADDR_ACR);
    frame_err_d = (instr_done && !instr_ok) ||
                  (cs_rise && (((state_q == ST_INSTR) && (cnt_q != 6'd0)) ||
                               (state_q == ST_DATA)));
  end

  // Register file: CSR, channel buffers and active outputs. FR1/FR2/CFR/CPOW0
  // words are framed with their proper lengths but have no storage here.
  // A transfer in the same cycle as a commit reads the old buffer value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csr_q          <= CSR_DEFAULT;
      ftw_buf0_q     <= '0;
      ftw_buf1_q     <= '0;
      acr_buf0_q     <= '0;
      acr_buf1_q     <= '0;
      ftw0_q         <= '0;
      ftw1_q         <= '0;
      acr0_q         <= '0;
      acr1_q         <= '0;
      update_pulse_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else if (mr_s) begin
      csr_q          <= CSR_DEFAULT;
      ftw_buf0_q     <= '0;
      ftw_buf1_q     <= '0;
      acr_buf0_q     <= '0;
      acr_buf1_q     <= '0;
      ftw0_q         <= '0;
      ftw1_q         <= '0;
      acr0_q         <= '0;
      acr1_q         <= '0;
      update_pulse_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      frame_error_q  <= frame_err_d;
      update_pulse_q <= io_rise;
      if (commit_csr) csr_q <= shift_nxt[7:0];
      if (commit_ftw && csr_q[6]) ftw_buf0_q <= shift_nxt;
      if (commit_ftw && csr_q[7]) ftw_buf1_q <= shift_nxt;
      if (commit_acr && csr_q[6]) acr_buf0_q <= shift_nxt[23:0];
      if (commit_acr && csr_q[7]) acr_buf1_q <= shift_nxt[23:0];
      if (io_rise) begin
        ftw0_q <= ftw_buf0_q;
        ftw1_q <= ftw_buf1_q;
        acr0_q <= acr_buf0_q;
        acr1_q <= acr_buf1_q;
      end
    end
  end

  assign ftw_ch0      = ftw0_q;
  assign ftw_ch1      = ftw1_q;
  assign acr_ch0      = acr0_q;
  assign acr_ch1      = acr1_q;
  assign update_pulse = update_pulse_q;
  assign frame_error  = frame_error_q;
  assign dbg_state    = state_q;

  logic unused_sync;
  assign unused_sync = ^{sync_q[7], sync_q[5], sync_rise[6], sync_rise[3:0],
                         sync_fall[7:5], sync_fall[3:0], shift_q[31]};

endmodule
